// File: rtl/cmsdk_ahb_arb_pkg.sv
// Shared types for the two-master AHB-to-APB arbiter.
// Master state, owner encoding and HTRANS values.
package cmsdk_ahb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PEND = 2'b01,
    ST_ACT  = 2'b10
  } mst_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_M0   = 2'b01,
    OWN_M1   = 2'b10
  } owner_t;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

endpackage

// File: rtl/cmsdk_ahb_arb_hold.sv
// Per-master address-phase hold register and
// IDLE/PEND/ACT state machine with response forwarding.
module cmsdk_ahb_arb_hold
  import cmsdk_ahb_arb_pkg::*;
#(
  parameter int ADDRWIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hsel,
  input  logic [ADDRWIDTH-1:0] haddr,
  input  logic [1:0]           htrans,
  input  logic [2:0]           hsize,
  input  logic [3:0]           hprot,
  input  logic                 hwrite,
  input  logic                 hready,
  input  logic                 issue,
  input  logic                 ds_ready,
  input  logic                 ds_resp,
  input  logic [31:0]          ds_rdata,
  output logic                 pend,
  output logic [ADDRWIDTH-1:0] addr,
  output logic [2:0]           size,
  output logic [3:0]           prot,
  output logic                 write,
  output logic                 hreadyout,
  output logic                 hresp,
  output logic [31:0]          hrdata
);

  mst_state_t state;
  logic       act;
  logic       done;
  logic       active_trans;
  logic       cap;

  assign act  = (state == ST_ACT);
  assign done = act & ds_ready;

  assign active_trans = (htrans == TRANS_NONSEQ)
                      | (htrans == TRANS_SEQ);

  // a new transfer may also land on the completing
  // cycle of the previous one (back-to-back)
  assign cap = hsel & active_trans & hready
             & ((state == ST_IDLE) | done);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      addr  <= '0;
      size  <= '0;
      prot  <= '0;
      write <= 1'b0;
    end else begin
      if (cap) begin
        addr  <= haddr;
        size  <= hsize;
        prot  <= hprot;
        write <= hwrite;
      end
      unique case (state)
        ST_IDLE: if (cap)   state <= ST_PEND;
        ST_PEND: if (issue) state <= ST_ACT;
        ST_ACT:  if (done)  state <= cap ? ST_PEND : ST_IDLE;
        default:            state <= ST_IDLE;
      endcase
    end
  end

  assign pend      = (state == ST_PEND);
  assign hreadyout = act ? ds_ready : (state != ST_PEND);
  assign hresp     = act & ds_resp;
  assign hrdata    = act ? ds_rdata : '0;

endmodule

// File: rtl/cmsdk_ahb_to_apb_arbiter.sv
// Two-master round-robin arbiter in front of the
// AHB-to-APB bridge slave port.
module cmsdk_ahb_to_apb_arbiter
  import cmsdk_ahb_arb_pkg::*;
#(
  parameter int ADDRWIDTH = 16
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic                 HSELM0,
  input  logic [ADDRWIDTH-1:0] HADDRM0,
  input  logic [1:0]           HTRANSM0,
  input  logic [2:0]           HSIZEM0,
  input  logic [3:0]           HPROTM0,
  input  logic                 HWRITEM0,
  input  logic                 HREADYM0,
  input  logic [31:0]          HWDATAM0,
  input  logic                 HSELM1,
  input  logic [ADDRWIDTH-1:0] HADDRM1,
  input  logic [1:0]           HTRANSM1,
  input  logic [2:0]           HSIZEM1,
  input  logic [3:0]           HPROTM1,
  input  logic                 HWRITEM1,
  input  logic                 HREADYM1,
  input  logic [31:0]          HWDATAM1,
  output logic                 HREADYOUTM0,
  output logic [31:0]          HRDATAM0,
  output logic                 HRESPM0,
  output logic                 HREADYOUTM1,
  output logic [31:0]          HRDATAM1,
  output logic                 HRESPM1,
  output logic                 HSELS,
  output logic [ADDRWIDTH-1:0] HADDRS,
  output logic [1:0]           HTRANSS,
  output logic [2:0]           HSIZES,
  output logic [3:0]           HPROTS,
  output logic                 HWRITES,
  output logic                 HREADYS,
  output logic [31:0]          HWDATAS,
  input  logic                 HREADYOUTS,
  input  logic [31:0]          HRDATAS,
  input  logic                 HRESPS,
  output logic [1:0]           ARB_OWNER
);

  owner_t                 dp_owner;
  owner_t                 last_grant;
  owner_t                 sel;
  logic                   pend0;
  logic                   pend1;
  logic                   issue;
  logic                   issue0;
  logic                   issue1;
  logic [ADDRWIDTH-1:0]   addr0;
  logic [ADDRWIDTH-1:0]   addr1;
  logic [2:0]             size0;
  logic [2:0]             size1;
  logic [3:0]             prot0;
  logic [3:0]             prot1;
  logic                   write0;
  logic                   write1;

  cmsdk_ahb_arb_hold #(.ADDRWIDTH(ADDRWIDTH)) u_hold0 (
    .clk       (HCLK),
    .rst       (HRESET),
    .hsel      (HSELM0),
    .haddr     (HADDRM0),
    .htrans    (HTRANSM0),
    .hsize     (HSIZEM0),
    .hprot     (HPROTM0),
    .hwrite    (HWRITEM0),
    .hready    (HREADYM0),
    .issue     (issue0),
    .ds_ready  (HREADYOUTS),
    .ds_resp   (HRESPS),
    .ds_rdata  (HRDATAS),
    .pend      (pend0),
    .addr      (addr0),
    .size      (size0),
    .prot      (prot0),
    .write     (write0),
    .hreadyout (HREADYOUTM0),
    .hresp     (HRESPM0),
    .hrdata    (HRDATAM0)
  );

  cmsdk_ahb_arb_hold #(.ADDRWIDTH(ADDRWIDTH)) u_hold1 (
    .clk       (HCLK),
    .rst       (HRESET),
    .hsel      (HSELM1),
    .haddr     (HADDRM1),
    .htrans    (HTRANSM1),
    .hsize     (HSIZEM1),
    .hprot     (HPROTM1),
    .hwrite    (HWRITEM1),
    .hready    (HREADYM1),
    .issue     (issue1),
    .ds_ready  (HREADYOUTS),
    .ds_resp   (HRESPS),
    .ds_rdata  (HRDATAS),
    .pend      (pend1),
    .addr      (addr1),
    .size      (size1),
    .prot      (prot1),
    .write     (write1),
    .hreadyout (HREADYOUTM1),
    .hresp     (HRESPM1),
    .hrdata    (HRDATAM1)
  );

  assign HREADYS = (dp_owner == OWN_NONE) | HREADYOUTS;
  assign issue   = HREADYS & (pend0 | pend1);

  always_comb begin
    sel = OWN_NONE;
    unique case (1'b1)
      pend0 & pend1:
        sel = (last_grant == OWN_M0) ? OWN_M1 : OWN_M0;
      pend0 & ~pend1: sel = OWN_M0;
      ~pend0 & pend1: sel = OWN_M1;
      default:        sel = OWN_NONE;
    endcase
  end

  assign issue0 = issue & (sel == OWN_M0);
  assign issue1 = issue & (sel == OWN_M1);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dp_owner   <= OWN_NONE;
      last_grant <= OWN_M1;
    end else if (issue) begin
      dp_owner   <= sel;
      last_grant <= sel;
    end else if (HREADYOUTS) begin
      dp_owner   <= OWN_NONE;
    end
  end

  assign HSELS   = issue;
  assign HTRANSS = issue ? TRANS_NONSEQ : TRANS_IDLE;

  always_comb begin
    HADDRS  = '0;
    HSIZES  = '0;
    HPROTS  = '0;
    HWRITES = 1'b0;
    if (issue0) begin
      HADDRS  = addr0;
      HSIZES  = size0;
      HPROTS  = prot0;
      HWRITES = write0;
    end else if (issue1) begin
      HADDRS  = addr1;
      HSIZES  = size1;
      HPROTS  = prot1;
      HWRITES = write1;
    end
  end

  always_comb begin
    HWDATAS = '0;
    unique case (dp_owner)
      OWN_M0:  HWDATAS = HWDATAM0;
      OWN_M1:  HWDATAS = HWDATAM1;
      default: HWDATAS = '0;
    endcase
  end

  assign ARB_OWNER = dp_owner;

endmodule
